motion_cmd_ctrl: RTL and testbench
==================================

// Module: motion_cmd_ctrl
// PURPOSE
//   Turns keyboard make/break events into held motion commands: rotate left/right, move forward/backward.
//   Tracks a held state for each of the 4 channels, with an optional auto-release timeout.
//   Gates each channel with its enable and cancels opposing commands on the same axis.
//   Emits periodic step pulses while a command is active. Sits between the keyboard decoder and the motion/render logic.
// PARAMETERS
//   KEY_LEFT      8'h61  key code for rotate-left  ('a')
//   KEY_RIGHT     8'h64  key code for rotate-right ('d')
//   KEY_FORWARD   8'h77  key code for move-forward ('w')
//   KEY_BACKWARD  8'h73  key code for move-backward ('s')
//   HOLD_TIMEOUT  1024   cycles without a refreshing make before auto-release; 0 = never time out
//   REPEAT_PERIOD 16     cycles between step pulses while active; must be >= 2
// PORTS
//   clk          in   1  system clock
//   rst          in   1  asynchronous, active-high reset
//   key_valid    in   1  one-cycle strobe: key_code/key_break valid
//   key_code     in   8  key code
//   key_break    in   1  1 = release (break), 0 = press (make)
//   en_left      in   1  enable, rotate-left
//   en_right     in   1  enable, rotate-right
//   en_forward   in   1  enable, move-forward
//   en_backward  in   1  enable, move-backward
//   rotate_sig   out  2  level: [1] left, [0] right
//   move_sig     out  2  level: [1] forward, [0] backward
//   rotate_step  out  2  one-cycle step pulses, same bit order as rotate_sig
//   move_step    out  2  one-cycle step pulses, same bit order as move_sig
//   held         out  4  raw held state {L,R,F,B}, before gating
// BEHAVIOUR
//   Reset: all outputs, held flags, timers and repeat counters = 0, effective immediately (async).
//   Channel index: 3 = L, 2 = R, 1 = F, 0 = B.
//   Decode when key_valid=1 and key_code matches a channel:
//     make  -> held=1, timer reloaded to HOLD_TIMEOUT (a make while already held also reloads)
//     break -> held=0, timer=0
//     unmatched codes, or key_valid=0 -> no event
//   Timeout (HOLD_TIMEOUT>0): the timer of a held channel decrements by 1 per cycle.
//     When it reaches 0, held clears on the edge where it goes 1 -> 0.
//     A make in the same cycle as expiry wins: held stays 1 and the timer reloads.
//   Gating and conflict, per axis (example: rotate):
//     act_L = held_L & en_left; act_R = held_R & en_right
//     rotate_sig = {act_L & ~act_R, act_R & ~act_L}, so both active -> 2'b00. Move axis is identical.
//   Timing: held and the *_sig outputs are registered, computed from next-state held and the current enables.
//     Latency: key_valid at edge N -> outputs change at edge N+1.
//     Enables take effect at the next edge. A disabled channel keeps tracking held and its timer.
//   Step pulses, per output bit:
//     A 0 -> 1 transition of the sig bit pulses the step bit in the same cycle the sig bit first reads 1.
//     While the sig bit stays 1, it pulses again every REPEAT_PERIOD cycles.
//     The repeat counter clears whenever the sig bit is 0.
//     Step is never 1 while sig is 0.
//   Widths: timer $clog2(HOLD_TIMEOUT+1) bits, repeat counter $clog2(REPEAT_PERIOD) bits. Both saturate at 0 and never wrap.
// STRUCTURE
//   Package motion_cmd_pkg holds:
//     channel index localparams CH_L=3, CH_R=2, CH_F=1, CH_B=0
//     default key-code constants
//   Sub-module motion_chan, instantiated 4 times:
//     inputs make/break strobes; holds the held flag and timeout timer; outputs held and held_nxt
//   Top level holds: key decode, enable/conflict gating, output registers, 4 repeat counters.
// TESTING (HOLD_TIMEOUT=8, REPEAT_PERIOD=4 unless noted)
//   1. Make 0x77, all enables 1:
//      move_sig=2'b10 from the next edge; move_step[1] pulses at cycles +1, +5, +9.
//      Break 0x77 at +6 -> move_sig=00 at +7, no further pulses.
//   2. Make 0x61, no further events:
//      rotate_sig[1] high for 8 cycles, then 0; held[3] clears.
//      Repeat with a second make at +5 -> stays high until +13.
//   3. Make 0x61 then make 0x64:
//      rotate_sig 10 -> 00 while both held.
//      Break 0x64 -> 10, with a fresh rotate_step[1] pulse.
//   4. en_forward=0, make 0x77: move_sig=00, held[1]=1.
//      Raise en_forward -> move_sig=10 next edge, with a step pulse.
//   5. Make 0x73 exactly at the expiry cycle -> held[0] stays 1.
//      key_code 0x78 with key_valid -> no state change.
//   6. Assert rst mid-hold, between clock edges:
//      all outputs 0 immediately; after rst drops, outputs stay 0 until a new make.

Source files
------------

// File: rtl/motion_cmd_pkg.sv
// motion_cmd_pkg: channel indices and default key codes for the motion command controller
package motion_cmd_pkg;
    localparam int CH_L = 3;
    localparam int CH_R = 2;
    localparam int CH_F = 1;
    localparam int CH_B = 0;
    localparam logic [7:0] DEF_KEY_LEFT     = 8'h61;
    localparam logic [7:0] DEF_KEY_RIGHT    = 8'h64;
    localparam logic [7:0] DEF_KEY_FORWARD  = 8'h77;
    localparam logic [7:0] DEF_KEY_BACKWARD = 8'h73;
endpackage

// File: rtl/motion_cmd_ctrl_chan.sv
// motion_chan: held flag and auto-release timer for one motion channel
module motion_chan #(
    parameter int unsigned HOLD_TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic mk,
    input  logic brk,
    output logic held,
    output logic held_nxt
);
    localparam int TW = HOLD_TIMEOUT > 0 ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(HOLD_TIMEOUT);
    logic [TW-1:0] timer, timer_nxt;
    // With HOLD_TIMEOUT = 0 the timer never leaves 0, so expiry can never fire
    always_comb begin
        held_nxt  = mk ? 1'b1 : brk ? 1'b0 : (held && timer == TW'(1)) ? 1'b0 : held;
        timer_nxt = mk ? TMAX : brk ? '0 : (held && timer != '0) ? timer - TW'(1) : timer;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held  <= 1'b0;
            timer <= '0;
        end else begin
            held  <= held_nxt;
            timer <= timer_nxt;
        end
    end
endmodule

// File: rtl/motion_cmd_ctrl.sv
// motion_cmd_ctrl: key make/break events to gated, conflict-free motion levels and repeating step pulses
module motion_cmd_ctrl
    import motion_cmd_pkg::*;
#(
    parameter logic [7:0]  KEY_LEFT      = DEF_KEY_LEFT,
    parameter logic [7:0]  KEY_RIGHT     = DEF_KEY_RIGHT,
    parameter logic [7:0]  KEY_FORWARD   = DEF_KEY_FORWARD,
    parameter logic [7:0]  KEY_BACKWARD  = DEF_KEY_BACKWARD,
    parameter int unsigned HOLD_TIMEOUT  = 1024,
    parameter int unsigned REPEAT_PERIOD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       key_break,
    input  logic       en_left,
    input  logic       en_right,
    input  logic       en_forward,
    input  logic       en_backward,
    output logic [1:0] rotate_sig,
    output logic [1:0] move_sig,
    output logic [1:0] rotate_step,
    output logic [1:0] move_step,
    output logic [3:0] held
);
    localparam int RW = $clog2(REPEAT_PERIOD);
    localparam logic [RW-1:0] CNT_LAST = RW'(REPEAT_PERIOD - 1);
    logic [3:0][7:0] codes;
    logic [3:0] mk, brk, held_nxt, en, act, sig_nxt, sig, step, step_nxt;
    assign codes = {KEY_LEFT, KEY_RIGHT, KEY_FORWARD, KEY_BACKWARD};
    assign en    = {en_left, en_right, en_forward, en_backward};
    assign act   = held_nxt & en;
    // Opposing channels on one axis cancel each other out
    assign sig_nxt = {act[CH_L] & ~act[CH_R], act[CH_R] & ~act[CH_L],
                      act[CH_F] & ~act[CH_B], act[CH_B] & ~act[CH_F]};
    genvar i;
    for (i = 0; i < 4; i++) begin : g_ch
        logic [RW-1:0] cnt;
        assign mk[i]  = key_valid & ~key_break & (key_code == codes[i]);
        assign brk[i] = key_valid &  key_break & (key_code == codes[i]);
        assign step_nxt[i] = sig_nxt[i] & (~sig[i] | cnt == CNT_LAST);
        motion_chan #(.HOLD_TIMEOUT(HOLD_TIMEOUT)) u_chan (
            .clk      (clk),
            .rst      (rst),
            .mk       (mk[i]),
            .brk      (brk[i]),
            .held     (held[i]),
            .held_nxt (held_nxt[i])
        );
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt     <= '0;
                sig[i]  <= 1'b0;
                step[i] <= 1'b0;
            end else begin
                cnt     <= (~sig_nxt[i] | step_nxt[i]) ? '0 : cnt + RW'(1);
                sig[i]  <= sig_nxt[i];
                step[i] <= step_nxt[i];
            end
        end
    end
    assign rotate_sig  = sig[3:2];
    assign move_sig    = sig[1:0];
    assign rotate_step = step[3:2];
    assign move_step   = step[1:0];
endmodule

// File: tb/tb_motion_cmd_ctrl.sv
// tb_motion_cmd_ctrl: directed vector table plus multi-cycle timeout and reset sequences
module tb_motion_cmd_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_valid = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_break = 1'b0;
    logic [3:0] en = 4'hF;
    logic [1:0] rotate_sig, move_sig, rotate_step, move_step;
    logic [3:0] held;
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    motion_cmd_ctrl #(.HOLD_TIMEOUT(8), .REPEAT_PERIOD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_break   (key_break),
        .en_left     (en[3]),
        .en_right    (en[2]),
        .en_forward  (en[1]),
        .en_backward (en[0]),
        .rotate_sig  (rotate_sig),
        .move_sig    (move_sig),
        .rotate_step (rotate_step),
        .move_step   (move_step),
        .held        (held)
    );

    typedef struct {
        logic        kv;
        logic [7:0]  code;
        logic        brk;
        logic [3:0]  en;
        logic [11:0] expv;
    } vec_t;
    vec_t vec [18];

    function automatic logic [11:0] obs();
        return {rotate_sig, move_sig, rotate_step, move_step, held};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, expv);
        end
    endtask

    task automatic tick(input logic kv, input logic [7:0] code, input logic brk);
        key_valid = kv;
        key_code  = code;
        key_break = brk;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        key_valid = 1'b0;
        en = 4'hF;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // fields: valid, code, break, enables, {rot, mov, rot_step, mov_step, held}
        vec[0]  = '{1'b0, 8'h00, 1'b0, 4'hF,   12'b00_00_00_00_0000};
        vec[1]  = '{1'b1, 8'h77, 1'b0, 4'hF,   12'b00_10_00_10_0010};
        vec[2]  = '{1'b0, 8'h00, 1'b0, 4'hF,   12'b00_10_00_00_0010};
        vec[3]  = '{1'b0, 8'h00, 1'b0, 4'hF,   12'b00_10_00_00_0010};
        vec[4]  = '{1'b0, 8'h00, 1'b0, 4'hF,   12'b00_10_00_00_0010};
        vec[5]  = '{1'b0, 8'h00, 1'b0, 4'hF,   12'b00_10_00_10_0010};
        vec[6]  = '{1'b1, 8'h77, 1'b1, 4'hF,   12'b00_00_00_00_0000};
        vec[7]  = '{1'b0, 8'h00, 1'b0, 4'hF,   12'b00_00_00_00_0000};
        vec[8]  = '{1'b1, 8'h78, 1'b0, 4'hF,   12'b00_00_00_00_0000};
        vec[9]  = '{1'b1, 8'h77, 1'b0, 4'b1101, 12'b00_00_00_00_0010};
        vec[10] = '{1'b0, 8'h00, 1'b0, 4'hF,   12'b00_10_00_10_0010};
        vec[11] = '{1'b1, 8'h61, 1'b0, 4'hF,   12'b10_10_10_00_1010};
        vec[12] = '{1'b1, 8'h64, 1'b0, 4'hF,   12'b00_10_00_00_1110};
        vec[13] = '{1'b1, 8'h64, 1'b1, 4'hF,   12'b10_10_10_00_1010};
        vec[14] = '{1'b1, 8'h73, 1'b0, 4'hF,   12'b10_00_00_00_1011};
        vec[15] = '{1'b1, 8'h73, 1'b1, 4'hF,   12'b10_10_00_10_1010};
        vec[16] = '{1'b1, 8'h61, 1'b1, 4'hF,   12'b00_10_00_00_0010};
        vec[17] = '{1'b0, 8'h00, 1'b0, 4'hF,   12'b00_00_00_00_0000};

        do_reset();
        check("reset_state", obs(), 12'h000);
        for (int v = 0; v < 18; v++) begin
            en = vec[v].en;
            tick(vec[v].kv, vec[v].code, vec[v].brk);
            check($sformatf("vec%0d", v), obs(), vec[v].expv);
        end

        // Auto-release: a single make holds for exactly 8 cycles
        do_reset();
        tick(1'b1, 8'h61, 1'b0);
        check("timeout_e1", {10'b0, rotate_sig}, {10'b0, 2'b10});
        for (int k = 2; k <= 9; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            check($sformatf("timeout_e%0d", k), {10'b0, rotate_sig}, {10'b0, (k <= 8) ? 2'b10 : 2'b00});
        end
        check("timeout_held", {11'b0, held[3]}, 12'h000);

        // A refreshing make at edge 5 extends the hold to edge 12
        do_reset();
        tick(1'b1, 8'h61, 1'b0);
        for (int k = 2; k <= 14; k++) begin
            tick(k == 5, 8'h61, 1'b0);
            check($sformatf("refresh_e%0d", k), {10'b0, rotate_sig}, {10'b0, (k <= 12) ? 2'b10 : 2'b00});
        end

        // A make landing on the expiry edge keeps the channel held
        do_reset();
        tick(1'b1, 8'h73, 1'b0);
        for (int k = 2; k <= 17; k++) begin
            tick(k == 9, 8'h73, 1'b0);
            check($sformatf("expiry_make_e%0d", k), {11'b0, held[0]}, {11'b0, k <= 16});
        end

        // Asynchronous reset between clock edges
        do_reset();
        tick(1'b1, 8'h77, 1'b0);
        tick(1'b0, 8'h00, 1'b0);
        check("pre_rst_hold", obs(), 12'b00_10_00_00_0010);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", obs(), 12'h000);
        #3;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 8'h00, 1'b0);
            check($sformatf("post_rst%0d", k), obs(), 12'h000);
        end
        tick(1'b1, 8'h77, 1'b0);
        check("post_rst_make", obs(), 12'b00_10_00_10_0010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
